// File: rtl/fir_pkg.sv
// Shared state encoding and control-word constants for the FIR compute engine.
package fir_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_IN,
      MAC,
      OUT,
      DONE
   } state_e;

   localparam int CTRL_AP_START_BIT = 0;
   localparam int CTRL_LEN_LSB      = 16;
   localparam int TAP_ADDR_STRIDE   = 4;

endpackage

// File: rtl/fir_core_engine_if.sv
// AXI-Stream sample-in / result-out bundle around the FIR engine.
interface fir_core_engine_if #(
   parameter int DATA_WIDTH = 32
) ();

   logic [DATA_WIDTH-1:0] ss_tdata;
   logic                  ss_tvalid;
   logic                  ss_tlast;
   logic                  ss_tready;

   logic [DATA_WIDTH-1:0] sm_tdata;
   logic                  sm_tvalid;
   logic                  sm_tlast;
   logic                  sm_tready;

   // master: sample source and result sink around the engine
   modport master (
      output ss_tdata, ss_tvalid, ss_tlast, sm_tready,
      input  ss_tready, sm_tdata, sm_tvalid, sm_tlast
   );

   modport slave (
      input  ss_tdata, ss_tvalid, ss_tlast, sm_tready,
      output ss_tready, sm_tdata, sm_tvalid, sm_tlast
   );

endinterface

// File: rtl/fir_shift_buffer.sv
// Sample delay line: newest sample at index 0, clearable, with a combinational read port.
module fir_shift_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 11,
   parameter int IDX_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  shift_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [IDX_W-1:0]      rd_idx_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] buf_q, buf_d;

   always_comb begin
      buf_d = buf_q;
      if (clr_i) begin
         buf_d = '0;
      end else if (shift_i) begin
         buf_d = {buf_q[DEPTH-2:0], wr_data_i};
      end
   end

   // NOTE: this storage is reset rather than left uninitialised: slots not yet filled must read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
      end else begin
         buf_q <= buf_d;
      end
   end

   assign rd_data_o = (rd_idx_i < IDX_W'(DEPTH)) ? buf_q[rd_idx_i] : '0;

endmodule

// File: rtl/fir_core_engine.sv
// FIR compute engine: per input sample, one tap-BRAM read per cycle feeds a wrapping MAC.
module fir_core_engine
   import fir_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_TAPS   = 11,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [DATA_WIDTH-1:0]   in_reg_data,
   output logic                    out_ap_done,
   output logic                    out_ap_idle,
   output logic [ADDR_WIDTH-1:0]   out_tap_A,
   output logic                    out_tap_EN,
   output logic [DATA_WIDTH/8-1:0] out_tap_WE,
   input  logic [DATA_WIDTH-1:0]   in_tap_Do,
   input  logic [DATA_WIDTH-1:0]   in_ss_tdata,
   input  logic                    in_ss_tvalid,
   input  logic                    in_ss_tlast,
   output logic                    out_ss_tready,
   output logic [DATA_WIDTH-1:0]   out_sm_tdata,
   output logic                    out_sm_tvalid,
   output logic                    out_sm_tlast,
   input  logic                    in_sm_tready
);

   localparam int K_W = $clog2(NUM_TAPS + 1);

   state_e                state_q, state_d;
   logic                  start_q;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [K_W-1:0]        k_q, k_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;

   logic                  start, accept_start, last_sample;
   logic                  tap_en, buf_clr, buf_shift;
   logic [LEN_WIDTH-1:0]  len_in;
   logic [K_W-1:0]        rd_idx;
   logic [DATA_WIDTH-1:0] buf_rd, product;
   logic                  unused_inputs;

   assign start        = in_reg_data[CTRL_AP_START_BIT] & ~start_q;
   assign accept_start = start & ((state_q == IDLE) || (state_q == DONE));
   assign len_in       = in_reg_data[CTRL_LEN_LSB +: LEN_WIDTH];
   assign last_sample  = (cnt_q == len_q - LEN_WIDTH'(1));
   assign rd_idx       = k_q - K_W'(1);
   // Low half of a signed product equals the unsigned one; the sum wraps likewise.
   assign product      = DATA_WIDTH'($signed(in_tap_Do) * $signed(buf_rd));
   assign unused_inputs = ^{in_ss_tlast, in_reg_data};

   fir_shift_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (NUM_TAPS),
      .IDX_W      (K_W)
   ) u_buf (
      .clk       (aclk),
      .rst_n     (aresetn),
      .clr_i     (buf_clr),
      .shift_i   (buf_shift),
      .wr_data_i (in_ss_tdata),
      .rd_idx_i  (rd_idx),
      .rd_data_o (buf_rd)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every output is defaulted before the case so no path can infer a latch.
      state_d       = state_q;
      out_ss_tready = 1'b0;
      out_sm_tvalid = 1'b0;
      out_sm_tlast  = 1'b0;
      tap_en        = 1'b0;
      buf_clr       = 1'b0;
      buf_shift     = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               buf_clr = 1'b1;
               state_d = (len_in == '0) ? DONE : WAIT_IN;
            end
         end
         WAIT_IN: begin
            out_ss_tready = 1'b1;
            if (in_ss_tvalid) begin
               buf_shift = 1'b1;
               state_d   = MAC;
            end
         end
         MAC: begin
            tap_en = (k_q < K_W'(NUM_TAPS));
            if (k_q == K_W'(NUM_TAPS)) state_d = OUT;
         end
         OUT: begin
            out_sm_tvalid = 1'b1;
            out_sm_tlast  = last_sample;
            if (in_sm_tready) state_d = last_sample ? DONE : WAIT_IN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Tap k is presented in cycle k and multiplied with buf[k] one cycle later.
   always_comb begin
      len_d = len_q;
      cnt_d = cnt_q;
      k_d   = k_q;
      acc_d = acc_q;
      if (accept_start) begin
         len_d = len_in;
         cnt_d = '0;
      end
      unique case (state_q)
         WAIT_IN: begin
            if (in_ss_tvalid) begin
               acc_d = '0;
               k_d   = '0;
            end
         end
         MAC: begin
            if (k_q != K_W'(NUM_TAPS)) k_d = k_q + K_W'(1);
            if (k_q != '0) acc_d = acc_q + product;
         end
         OUT: begin
            if (in_sm_tready) cnt_d = cnt_q + LEN_WIDTH'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         start_q <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         k_q     <= '0;
         acc_q   <= '0;
      end else begin
         start_q <= in_reg_data[CTRL_AP_START_BIT];
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
      end
   end

   assign out_tap_EN   = tap_en;
   assign out_tap_A    = tap_en ? ADDR_WIDTH'(int'(k_q) * TAP_ADDR_STRIDE) : '0;
   assign out_tap_WE   = '0;
   assign out_sm_tdata = acc_q;
   assign out_ap_done  = (state_q == DONE);
   assign out_ap_idle  = (state_q == IDLE) || (state_q == DONE);

endmodule

// File: doc/fir_core_engine.md
Name: fir_core_engine

Overview:
- Compute stage directly downstream of the AXI4-Lite slave front-end; consumes its control-register word and the tap-coefficient BRAM it fills.
- On an ap_start rising edge, streams data_length samples in over AXI-Stream and computes a NUM_TAPS-tap FIR per sample (one 1-cycle-latency BRAM read per tap).
- Streams each result out, then asserts ap_done back to the register slave.

Parameters:
- ADDR_WIDTH, 12, tap BRAM byte-address width
- DATA_WIDTH, 32, sample/tap/result width; control-word width
- NUM_TAPS, 11, tap count; also data-buffer depth
- LEN_WIDTH, 16, data_length field width

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- in_reg_data  in  DATA_WIDTH  control word: bit0 = ap_start (level); bits [16+LEN_WIDTH-1:16] = data_length
- out_ap_done  out  1  job complete (level)
- out_ap_idle  out  1  engine in IDLE
- out_tap_A  out  ADDR_WIDTH  tap BRAM byte address
- out_tap_EN  out  1  tap BRAM read enable
- out_tap_WE  out  DATA_WIDTH/8  tied 0
- in_tap_Do  in  DATA_WIDTH  tap read data, valid 1 cycle after EN
- in_ss_tdata  in  DATA_WIDTH  input sample
- in_ss_tvalid  in  1  input valid
- in_ss_tlast  in  1  input last; ignored (length is authoritative)
- out_ss_tready  out  1  input ready
- out_sm_tdata  out  DATA_WIDTH  result
- out_sm_tvalid  out  1  result valid
- out_sm_tlast  out  1  last result of job
- in_sm_tready  in  1  downstream ready

Behaviour:
- Reset values: out_ap_done=0, out_ap_idle=1, out_tap_EN=0, out_tap_A=0, out_ss_tready=0, out_sm_tvalid=0, out_sm_tlast=0, out_sm_tdata=0. State is IDLE; counters, accumulator and data buffer are 0.
- start = in_reg_data[0] & ~start_q, where start_q is registered bit0. start is acted on only in IDLE or DONE; it is ignored in all other states.
- On start:
  - Latch data_length.
  - Clear the data buffer and sample counter.
  - Drop out_ap_done and out_ap_idle.
  - If data_length==0, go to DONE; otherwise go to WAIT_IN.
- WAIT_IN:
  - out_ss_tready=1.
  - On tvalid&tready: shift buf[NUM_TAPS-1:1] <= buf[NUM_TAPS-2:0], buf[0] <= tdata; clear acc and tap index k; go to MAC.
- MAC (NUM_TAPS+1 cycles, c = 0..NUM_TAPS):
  - For c < NUM_TAPS: out_tap_EN=1, out_tap_A = c*4.
  - For c >= 1: acc <= acc + lowbits(in_tap_Do * buf[c-1]).
  - Multiply is signed; both product and accumulator are truncated to DATA_WIDTH (two's-complement wrap, no saturation).
  - After c = NUM_TAPS, go to OUT.
- OUT:
  - out_sm_tvalid=1, out_sm_tdata=acc.
  - out_sm_tlast=1 iff sample_cnt == data_length-1.
  - tdata and tlast hold stable while tvalid=1 and in_sm_tready=0.
  - On handshake: sample_cnt++; if this was the last sample go to DONE, else go to WAIT_IN.
- Latency: the first MAC cycle is the cycle after the input handshake edge. tvalid rises NUM_TAPS+1 cycles after that edge (12 at default). Minimum sample period is NUM_TAPS+3 cycles.
- DONE:
  - out_ap_done=1 and out_ap_idle=1; both held until the next start.
  - Leaves DONE only via start.
- IDLE→DONE via length 0 takes one cycle.
- ap_start held high does not retrigger; it must deassert and reassert.
- Asynchronous reset mid-job returns every output to its reset value immediately. No partial result is emitted.
- Buffer samples not yet received read as 0, giving zero-padded startup.

Decomposition:
- fir_pkg:
  - state enum: IDLE, WAIT_IN, MAC, OUT, DONE
  - constants: CTRL_AP_START_BIT=0, CTRL_LEN_LSB=16, TAP_ADDR_STRIDE=4
- One sub-module: fir_shift_buffer (NUM_TAPS-deep shift register with clear, shift-enable and combinational indexed read port).
- FSM, counters and MAC stay in fir_core_engine.

Test Plan:
- Basic FIR: taps all 1; length=5; inputs 1,2,3,4,5 with tready=1 → outputs 1,3,6,10,15. tlast on the 5th output only; ap_done rises after the 5th handshake.
- Tap ordering: taps t[i]=i+1; length=2; inputs 10,0 → outputs 10, 20. Also check EN/A sequence 0x00..0x28 per sample and tap WE always 0.
- Backpressure: hold in_sm_tready=0 for 7 cycles in OUT → tvalid, tdata and tlast stable; then exactly one transfer. ss_tready stays 0 throughout.
- Length 0 and retrigger: length=0 start → ap_done=1 one cycle later with no stream activity. Toggling ap_start during MAC is ignored; a new start from DONE clears ap_done.
- Wrap arithmetic: taps all 1; inputs 0x7FFFFFFF,1 → outputs 0x7FFFFFFF, 0x80000000. Tap 0xFFFFFFFF × input 3 → 0xFFFFFFFD.
- Reset mid-job: assert aresetn=0 in the 4th MAC cycle of sample 2 → outputs at reset values immediately. A fresh job then reproduces scenario 1 exactly, with no stale buffer data.
